// File: rtl/mac_node.sv
// Serial multiply-accumulate node: N_IN signed pairs in, one saturated result out.
// Optional ReLU on the result when MAC_NODE_RELU_EN is defined.
module mac_node #(
  parameter int WIDTH = 10,
  parameter int N_IN  = 4,
  parameter int FRAC  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic signed [WIDTH-1:0] in_weight,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends combinationally on ready, and held data stays stable until the transfer.

  localparam int CW = $clog2(N_IN);
  localparam int PW = 2 * WIDTH;
  localparam int AW = PW + CW;
  localparam logic signed [AW-1:0] SMAX = $signed({{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
  localparam logic signed [AW-1:0] SMIN = $signed({{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic signed [AW-1:0]    acc;
  logic [CW-1:0]           cnt;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    sum;
  logic signed [AW-1:0]    shifted;
  logic signed [WIDTH-1:0] result;
  logic                    accept;
  logic                    last;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign dbg_state = state;
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == CW'(N_IN - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
    if (clr) state_nxt = ACCUM;
  end

  // Full-precision product; the -2^(W-1) * -2^(W-1) corner fits in 2*WIDTH bits.
  always_comb begin
    prod    = in_data * in_weight;
    sum     = acc + {{CW{prod[PW-1]}}, prod};
    shifted = sum >>> FRAC;
    if (shifted > SMAX)      result = {1'b0, {(WIDTH-1){1'b1}}};
    else if (shifted < SMIN) result = {1'b1, {(WIDTH-1){1'b0}}};
    else                     result = shifted[WIDTH-1:0];
`ifdef MAC_NODE_RELU_EN
    if (result[WIDTH-1]) result = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        if (last) begin
          acc      <= '0;
          cnt      <= '0;
          out_data <= result;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end else if (out_valid && out_ready) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mac_node.sv
// Directed bench for mac_node: one FRAC=0 and one FRAC=4 instance driven in lockstep.
module tb_mac_node;

  logic clk, rst_n, clr, in_valid, out_ready;
  logic signed [9:0] in_data, in_weight;
  logic in_ready0, out_valid0, dbg0, in_ready4, out_valid4, dbg4;
  logic signed [9:0] out_data0, out_data4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int d[4];
    int w[4];
    int e0;
    int e4;
  } vec_t;
  vec_t vecs[10];

  mac_node #(.WIDTH(10), .N_IN(4), .FRAC(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .dbg_state(dbg0));

  mac_node #(.WIDTH(10), .N_IN(4), .FRAC(4)) dut_f (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .dbg_state(dbg4));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] act(input int v);
    int r;
    r = v;
`ifdef MAC_NODE_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[9:0];
  endfunction

  task automatic chk(input string name, input logic [9:0] actual, input logic [9:0] expv);
    checks++;
    if (actual !== expv) begin
      errors++;
      $display("FAIL %s actual=0x%03h expected=0x%03h", name, actual, expv);
    end
  endtask

  task automatic send_pair(input int d, input int w);
    int t;
    t = 0;
    in_data   = 10'(d);
    in_weight = 10'(w);
    in_valid  = 1'b1;
    while (!(in_ready0 && in_ready4) && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 20) chk("in_ready_timeout", {9'd0, in_ready0}, 10'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Sends a vector's pairs and checks latency/result; leaves the node in DONE.
  task automatic eval_vec(input int k);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk($sformatf("v%0d_ov_before_last", k), {9'd0, out_valid0}, 10'd0);
      send_pair(vecs[k].d[i], vecs[k].w[i]);
    end
    chk($sformatf("v%0d_out_valid", k), {9'd0, out_valid0}, 10'd1);
    chk($sformatf("v%0d_out_valid_f", k), {9'd0, out_valid4}, 10'd1);
    chk($sformatf("v%0d_in_ready", k), {9'd0, in_ready0}, 10'd0);
    chk($sformatf("v%0d_out_data", k), out_data0, act(vecs[k].e0));
    chk($sformatf("v%0d_out_data_f", k), out_data4, act(vecs[k].e4));
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_in_ready"}, {9'd0, in_ready0}, 10'd1);
    chk({name, "_out_valid"}, {9'd0, out_valid0}, 10'd0);
  endtask

  initial begin
    vecs[0] = '{d: '{3, -4, 7, 0},         w: '{2, 5, 1, 9},       e0: -7,   e4: -1};
    vecs[1] = '{d: '{511, 511, 511, 511},  w: '{511, 511, 511, 511}, e0: 511, e4: 511};
    vecs[2] = '{d: '{-512, -512, -512, -512}, w: '{511, 511, 511, 511}, e0: -512, e4: -512};
    vecs[3] = '{d: '{-512, -512, -512, -512}, w: '{-512, -512, -512, -512}, e0: 511, e4: 511};
    vecs[4] = '{d: '{10, 10, 10, 10},      w: '{8, 8, 8, 8},       e0: 320,  e4: 20};
    vecs[5] = '{d: '{-1, 0, 0, 0},         w: '{1, 0, 0, 0},       e0: -1,   e4: -1};
    vecs[6] = '{d: '{2, 2, 2, 2},          w: '{3, 3, 3, 3},       e0: 24,   e4: 1};
    vecs[7] = '{d: '{1, 1, 1, 1},          w: '{1, 1, 1, 1},       e0: 4,    e4: 0};
    vecs[8] = '{d: '{100, -50, 0, 25},     w: '{-3, 2, 0, 4},      e0: -300, e4: -19};
    vecs[9] = '{d: '{20, 20, 1, 0},        w: '{20, 20, 1, 5},     e0: 511,  e4: 50};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_weight = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {9'd0, in_ready0}, 10'd1);
    chk("rst_out_valid", {9'd0, out_valid0}, 10'd0);
    chk("rst_out_data", out_data0, 10'd0);
    chk("rst_out_data_f", out_data4, 10'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 10; k++) begin
      eval_vec(k);
      release_out($sformatf("v%0d_rel", k));
    end

    // Back-pressure: result held, input pulses ignored.
    eval_vec(1);
    for (int i = 0; i < 5; i++) begin
      in_valid  = (i % 2 == 0);
      in_data   = 10'sd7;
      in_weight = 10'sd7;
      @(posedge clk); #1;
      chk($sformatf("hold%0d_out_valid", i), {9'd0, out_valid0}, 10'd1);
      chk($sformatf("hold%0d_in_ready", i), {9'd0, in_ready0}, 10'd0);
      chk($sformatf("hold%0d_out_data", i), out_data0, act(511));
    end
    in_valid = 1'b0;
    release_out("hold_rel");
    eval_vec(4);
    release_out("hold_next_rel");

    // Soft clear aborts a partial evaluation and wins over a coincident input.
    send_pair(100, 100);
    send_pair(100, 100);
    clr = 1'b1; in_valid = 1'b1; in_data = 10'sd100; in_weight = 10'sd100;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_in_ready", {9'd0, in_ready0}, 10'd1);
    chk("clr_out_data_kept", out_data0, act(320));
    eval_vec(7);
    // Soft clear in DONE drops out_valid but keeps out_data.
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_done_out_valid", {9'd0, out_valid0}, 10'd0);
    chk("clr_done_out_data", out_data0, act(4));

    // Asynchronous reset mid-evaluation.
    eval_vec(9);
    release_out("pre_rst_rel");
    send_pair(5, 5);
    send_pair(5, 5);
    send_pair(5, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_data", out_data0, 10'd0);
    chk("arst_out_data_f", out_data4, 10'd0);
    chk("arst_in_ready", {9'd0, in_ready0}, 10'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    eval_vec(6);
    release_out("post_rst_rel");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/mac_node.md
MAC_NODE -- requirements
Module: mac_node

Interface
REQ-001 Parameter WIDTH, default 10: signed two's-complement width of data, weight and result.
REQ-002 Parameter N_IN, default 4: number of data/weight pairs per node evaluation (N_IN >= 2).
REQ-003 Parameter FRAC, default 0: number of fractional bits removed from the accumulated sum before output.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 clr  input  1: synchronous soft clear, aborts the evaluation in progress.
REQ-007 in_valid  input  1: in_data/in_weight pair is valid.
REQ-008 in_ready  output  1: node accepts a pair this cycle.
REQ-009 in_data  input  WIDTH: signed operand.
REQ-010 in_weight  input  WIDTH: signed multiplier for in_data.
REQ-011 out_valid  output  1: out_data holds a completed node result.
REQ-012 out_ready  input  1: consumer accepts out_data.
REQ-013 out_data  output  WIDTH: signed node result.

Function
REQ-014 The node SHALL compute out_data = sat(sum over N_IN pairs of in_data*in_weight >>> FRAC), serially, one pair per accepted handshake.
REQ-015 A pair SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-016 Two states SHALL exist: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-017 In ACCUM, each accepted pair SHALL add its full 2*WIDTH-bit signed product to an accumulator of 2*WIDTH+clog2(N_IN) bits (no internal overflow) and increment a pair counter.
REQ-018 Acceptance of pair N_IN (counter == N_IN-1) SHALL move ACCUM->DONE and register out_data; out_valid SHALL be 1 on the next cycle (latency 1 cycle after the last handshake).
REQ-019 The accumulated sum SHALL be arithmetic-shifted right by FRAC (truncation toward minus infinity), then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 In DONE, out_data and out_valid SHALL hold stable until out_ready=1; that cycle SHALL move DONE->ACCUM with accumulator and counter cleared, so in_ready=1 the next cycle.
REQ-021 in_valid while in DONE SHALL be ignored (no accumulation, no counter change).
REQ-022 clr=1 SHALL, on the next edge, force ACCUM, clear accumulator, counter and out_valid; out_data SHALL retain its last value.
REQ-023 clr=1 simultaneous with an input or output handshake SHALL take priority; the handshake has no effect.
REQ-024 in_data or in_weight equal to -2^(WIDTH-1) SHALL be handled exactly (product -2^(WIDTH-1) * -2^(WIDTH-1) representable).

Reset
REQ-025 rst_n=0 SHALL immediately, independent of clk, set state ACCUM, accumulator 0, counter 0, out_valid 0, out_data 0.
REQ-026 Reset asserted mid-evaluation SHALL discard all accepted pairs; the first pair after release starts a new evaluation.

Configuration
REQ-027 Macro MAC_NODE_RELU_EN defined: out_data SHALL be max(0, saturated result) (ReLU activation applied after saturation).
REQ-028 MAC_NODE_RELU_EN undefined: out_data SHALL be the signed saturated result with no activation; all other behaviour identical.

Verification (WIDTH=10, N_IN=4, FRAC=0 unless stated)
REQ-029 Pairs (3,2),(-4,5),(7,1),(0,9), back-to-back -> out_valid 1 cycle after 4th handshake, out_data = -7 (0x3F9); with MAC_NODE_RELU_EN, out_data = 0.
REQ-030 Four pairs (511,511) -> out_data = 511 (0x1FF); four pairs (-512,511) -> out_data = -512 (0x200); four pairs (-512,-512) -> 511.
REQ-031 out_ready held 0 for 5 cycles after out_valid -> out_data stable, in_ready 0, in_valid pulses ignored; out_ready=1 -> in_ready 1 next cycle, next evaluation unaffected.
REQ-032 Two pairs (100,100) accepted, then clr=1 coincident with in_valid, then four pairs (1,1) -> out_data = 4.
REQ-033 FRAC=4: four pairs (10,8) -> sum 320 -> out_data = 20; single nonzero pair (-1,1) with three (0,0) -> out_data = -1.
REQ-034 rst_n pulsed low asynchronously after 3 accepted pairs -> outputs reset immediately; four pairs (2,3) afterwards -> out_data = 24.
